lcd_port_arbiter: RTL and testbench

Shares the single byte-wide LCD SPI driver (`lcd_data_in` / `lcd_data_dcx` / `lcd_start` / `lcd_done`) between two requesters:

- **Command port:** single host bytes from the memory-mapped interface.
- **Pixel port:** 16-bit RGB565 words from the line-RAM framebuffer dumper.

Each pixel word is split into two data bytes, high byte first. A pixel burst can optionally be prefixed with a RAMWR command byte. The arbiter locks the driver to the pixel port until the burst's last word has been fully sent. The block sits between `mmap_interface` and the LCD driver and replaces ad-hoc driver sharing.

---
 rtl/lcd_port_arbiter_if.sv | 30 +++
 rtl/lcd_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_lcd_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_port_arbiter_if.sv
// Requester-side bundle for lcd_port_arbiter: one command port and one pixel port.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// the requester keeps valid and its payload stable until that edge, ready may depend
// combinationally on valid, and the done outputs are single-cycle registered pulses.
interface lcd_port_arbiter_if;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_dcx;
  logic        cmd_ready;
  logic        cmd_done;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        pix_done;

  modport master (
    output cmd_valid, cmd_data, cmd_dcx,
    input  cmd_ready, cmd_done,
    output pix_valid, pix_data, pix_last,
    input  pix_ready, pix_done
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dcx,
    output cmd_ready, cmd_done,
    input  pix_valid, pix_data, pix_last,
    output pix_ready, pix_done
  );
endinterface

// File: rtl/lcd_port_arbiter.sv
// Shares one byte-wide LCD driver between a command port (single bytes) and a pixel
// port (RGB565 words sent high byte first, optionally prefixed by a RAMWR header).
// Once a pixel burst starts, the driver stays locked to the pixel port until the
// word flagged last has been fully sent.
module lcd_port_arbiter #(
  parameter bit         RAMWR_AUTO = 1'b1,
  parameter logic [7:0] RAMWR_BYTE = 8'h2C
) (
  input  logic                clk,
  input  logic                rst,
  lcd_port_arbiter_if.slave   bus,
  output logic [16:0]         burst_words,
  output logic                busy,
  output logic [7:0]          lcd_data_in,
  output logic                lcd_data_dcx,
  output logic                lcd_start,
  input  logic                lcd_done,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_WAIT = 3'd1,
    S_HDR_WAIT = 3'd2,
    S_HI_WAIT  = 3'd3,
    S_LO_WAIT  = 3'd4,
    S_PIX_NEXT = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        last_q, last_d;
  logic [16:0] word_cnt_q, word_cnt_d;
  logic [16:0] burst_words_q, burst_words_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_dcx_q, lcd_dcx_d;
  logic        lcd_start_q, lcd_start_d;
  logic        cmd_done_q, cmd_done_d;
  logic        pix_done_q, pix_done_d;

  logic        cmd_ready_c;
  logic        pix_ready_c;
  logic        cmd_acc;
  logic        pix_acc;
  logic        done_ok;
  logic [16:0] cnt_inc;

  // A done coinciding with our own start pulse belongs to the previous byte, so drop it.
  assign done_ok = lcd_done & ~lcd_start_q;
  assign cmd_acc = bus.cmd_valid & cmd_ready_c;
  assign pix_acc = bus.pix_valid & pix_ready_c;
  assign cnt_inc = (word_cnt_q == 17'h1FFFF) ? word_cnt_q : word_cnt_q + 17'd1;

  // State and datapath registers; reset drops any latched word and the burst lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_q        <= 16'h0000;
      last_q        <= 1'b0;
      word_cnt_q    <= 17'd0;
      burst_words_q <= 17'd0;
      lcd_data_q    <= 8'h00;
      lcd_dcx_q     <= 1'b0;
      lcd_start_q   <= 1'b0;
      cmd_done_q    <= 1'b0;
      pix_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      last_q        <= last_d;
      word_cnt_q    <= word_cnt_d;
      burst_words_q <= burst_words_d;
      lcd_data_q    <= lcd_data_d;
      lcd_dcx_q     <= lcd_dcx_d;
      lcd_start_q   <= lcd_start_d;
      cmd_done_q    <= cmd_done_d;
      pix_done_q    <= pix_done_d;
    end
  end

  // Next-state: command wins in IDLE, pixel burst holds the driver until its last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc)      state_d = S_CMD_WAIT;
        else if (pix_acc) state_d = RAMWR_AUTO ? S_HDR_WAIT : S_HI_WAIT;
      end
      S_CMD_WAIT: if (done_ok) state_d = S_IDLE;
      S_HDR_WAIT: if (done_ok) state_d = S_HI_WAIT;
      S_HI_WAIT:  if (done_ok) state_d = S_LO_WAIT;
      S_LO_WAIT:  if (done_ok) state_d = last_q ? S_IDLE : S_PIX_NEXT;
      S_PIX_NEXT: if (pix_acc) state_d = S_HI_WAIT;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs: ready decode plus the byte issued to the driver on each transition.
  always_comb begin
    cmd_ready_c   = (state_q == S_IDLE);
    pix_ready_c   = ((state_q == S_IDLE) & ~bus.cmd_valid) | (state_q == S_PIX_NEXT);
    word_d        = word_q;
    last_d        = last_q;
    word_cnt_d    = word_cnt_q;
    burst_words_d = burst_words_q;
    lcd_data_d    = lcd_data_q;
    lcd_dcx_d     = lcd_dcx_q;
    lcd_start_d   = 1'b0;
    cmd_done_d    = 1'b0;
    pix_done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          lcd_data_d  = bus.cmd_data;
          lcd_dcx_d   = bus.cmd_dcx;
          lcd_start_d = 1'b1;
        end else if (pix_acc) begin
          word_d      = bus.pix_data;
          last_d      = bus.pix_last;
          word_cnt_d  = 17'd0;
          lcd_start_d = 1'b1;
          if (RAMWR_AUTO) begin
            lcd_data_d = RAMWR_BYTE;
            lcd_dcx_d  = 1'b0;
          end else begin
            lcd_data_d = bus.pix_data[15:8];
            lcd_dcx_d  = 1'b1;
          end
        end
      end
      S_CMD_WAIT: begin
        if (done_ok) cmd_done_d = 1'b1;
      end
      S_HDR_WAIT: begin
        if (done_ok) begin
          lcd_data_d  = word_q[15:8];
          lcd_dcx_d   = 1'b1;
          lcd_start_d = 1'b1;
        end
      end
      S_HI_WAIT: begin
        if (done_ok) begin
          lcd_data_d  = word_q[7:0];
          lcd_dcx_d   = 1'b1;
          lcd_start_d = 1'b1;
        end
      end
      S_LO_WAIT: begin
        if (done_ok) begin
          word_cnt_d = cnt_inc;
          if (last_q) begin
            burst_words_d = cnt_inc;
            pix_done_d    = 1'b1;
          end
        end
      end
      S_PIX_NEXT: begin
        if (pix_acc) begin
          word_d      = bus.pix_data;
          last_d      = bus.pix_last;
          lcd_data_d  = bus.pix_data[15:8];
          lcd_dcx_d   = 1'b1;
          lcd_start_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.pix_ready = pix_ready_c;
  assign bus.cmd_done  = cmd_done_q;
  assign bus.pix_done  = pix_done_q;
  assign burst_words   = burst_words_q;
  assign busy          = (state_q != S_IDLE);
  assign lcd_data_in   = lcd_data_q;
  assign lcd_data_dcx  = lcd_dcx_q;
  assign lcd_start     = lcd_start_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Directed bench for lcd_port_arbiter: one instance with the RAMWR header enabled,
// a second with it disabled, driver handshakes emulated step by step.
module tb_lcd_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  lcd_port_arbiter_if bus1 ();
  lcd_port_arbiter_if bus0 ();

  logic [16:0] burst_words, burst_words0;
  logic        busy, busy0;
  logic [7:0]  lcd_data_in, lcd_data_in0;
  logic        lcd_data_dcx, lcd_data_dcx0;
  logic        lcd_start, lcd_start0;
  logic        lcd_done, lcd_done0;
  logic [2:0]  state_dbg, state_dbg0;

  lcd_port_arbiter #(.RAMWR_AUTO(1'b1), .RAMWR_BYTE(8'h2C)) dut (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .burst_words(burst_words), .busy(busy),
    .lcd_data_in(lcd_data_in), .lcd_data_dcx(lcd_data_dcx),
    .lcd_start(lcd_start), .lcd_done(lcd_done), .state_dbg(state_dbg)
  );

  lcd_port_arbiter #(.RAMWR_AUTO(1'b0), .RAMWR_BYTE(8'h2C)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .burst_words(burst_words0), .busy(busy0),
    .lcd_data_in(lcd_data_in0), .lcd_data_dcx(lcd_data_dcx0),
    .lcd_start(lcd_start0), .lcd_done(lcd_done0), .state_dbg(state_dbg0)
  );

  // Clock
  always #5 clk = ~clk;

  // Byte log and done-pulse counters, sampled mid-cycle
  logic [8:0] got_q[$];
  logic [8:0] got0_q[$];
  int cmd_done_cnt = 0;
  int pix_done_cnt = 0;
  int pix_done0_cnt = 0;

  always @(negedge clk) begin
    if (lcd_start)  got_q.push_back({lcd_data_dcx, lcd_data_in});
    if (lcd_start0) got0_q.push_back({lcd_data_dcx0, lcd_data_in0});
    if (bus1.cmd_done) cmd_done_cnt++;
    if (bus1.pix_done) pix_done_cnt++;
    if (bus0.pix_done) pix_done0_cnt++;
  end

  logic [8:0] exp_q[$];
  logic [8:0] exp0_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input bit sel, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sel ? lcd_start0 : lcd_start) break;
      tick();
    end
    chk({tag, "_start"}, 32'(sel ? lcd_start0 : lcd_start), 32'd1);
  endtask

  // Emulate the driver: let the byte run lat cycles after its start, then pulse done.
  task automatic serve(input bit sel, input int lat, input string tag);
    wait_start(sel, tag);
    repeat (lat) tick();
    if (sel) lcd_done0 = 1'b1; else lcd_done = 1'b1;
    tick();
    lcd_done0 = 1'b0;
    lcd_done  = 1'b0;
  endtask

  task automatic check_log(input string tag, input bit sel);
    int n;
    if (sel) begin
      chk({tag, "_count"}, 32'(got0_q.size()), 32'(exp0_q.size()));
      n = (got0_q.size() < exp0_q.size()) ? got0_q.size() : exp0_q.size();
      for (int i = 0; i < n; i++)
        chk($sformatf("%s_byte%0d", tag, i), 32'(got0_q[i]), 32'(exp0_q[i]));
    end else begin
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
        chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    rst = 1'b1;
    lcd_done = 1'b0;
    lcd_done0 = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_data = 8'h00; bus1.cmd_dcx = 1'b0;
    bus1.pix_valid = 1'b0; bus1.pix_data = 16'h0000; bus1.pix_last = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_data = 8'h00; bus0.cmd_dcx = 1'b0;
    bus0.pix_valid = 1'b0; bus0.pix_data = 16'h0000; bus0.pix_last = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_data", 32'(lcd_data_in), 32'h00);
    chk("rst_dcx", 32'(lcd_data_dcx), 32'd0);
    chk("rst_start", 32'(lcd_start), 32'd0);
    chk("rst_cmd_done", 32'(bus1.cmd_done), 32'd0);
    chk("rst_pix_done", 32'(bus1.pix_done), 32'd0);
    chk("rst_burst_words", 32'(burst_words), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    chk("rst_pix_ready_idle", 32'(bus1.pix_ready), 32'd1);

    // Single command 2A/0, driver done 5 cycles after start
    bus1.cmd_valid = 1'b1; bus1.cmd_data = 8'h2A; bus1.cmd_dcx = 1'b0;
    #1;
    chk("rst_pix_ready_cmd", 32'(bus1.pix_ready), 32'd0);
    exp_q.push_back({1'b0, 8'h2A});
    tick();
    bus1.cmd_valid = 1'b0;
    chk("cmd_start", 32'(lcd_start), 32'd1);
    chk("cmd_byte", 32'({lcd_data_dcx, lcd_data_in}), 32'h02A);
    chk("cmd_busy", 32'(busy), 32'd1);
    chk("cmd_wait_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
    tick();
    chk("cmd_start_pulse", 32'(lcd_start), 32'd0);
    chk("cmd_wait_state", 32'(state_dbg), 32'd1);
    tick(); tick(); tick();
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    chk("cmd_done_pulse", 32'(bus1.cmd_done), 32'd1);
    chk("cmd_idle", 32'(state_dbg), 32'd0);
    tick();
    chk("cmd_done_clear", 32'(bus1.cmd_done), 32'd0);
    chk("cmd_no_restart", 32'(lcd_start), 32'd0);
    check_log("single_cmd", 1'b0);

    // Simultaneous request: command wins, burst follows right after cmd_done
    bus1.cmd_valid = 1'b1; bus1.cmd_data = 8'h11; bus1.cmd_dcx = 1'b1;
    bus1.pix_valid = 1'b1; bus1.pix_data = 16'hF800; bus1.pix_last = 1'b0;
    #1;
    chk("sim_pix_ready", 32'(bus1.pix_ready), 32'd0);
    chk("sim_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
    exp_q.push_back({1'b1, 8'h11});
    tick();
    bus1.cmd_valid = 1'b0;
    chk("sim_cmd_first", 32'({lcd_data_dcx, lcd_data_in}), 32'h111);
    chk("sim_pix_blocked", 32'(bus1.pix_ready), 32'd0);
    serve(1'b0, 3, "sim_cmd");
    chk("sim_cmd_done", 32'(bus1.cmd_done), 32'd1);
    chk("sim_pix_ready_after", 32'(bus1.pix_ready), 32'd1);

    // 3-word burst with RAMWR header
    exp_q.push_back({1'b0, 8'h2C});
    exp_q.push_back({1'b1, 8'hF8});
    exp_q.push_back({1'b1, 8'h00});
    tick();
    bus1.pix_valid = 1'b0;
    chk("hdr_start", 32'(lcd_start), 32'd1);
    chk("hdr_state", 32'(state_dbg), 32'd2);
    serve(1'b0, 2, "hdr");
    chk("hi_state", 32'(state_dbg), 32'd3);
    serve(1'b0, 2, "w0_hi");
    serve(1'b0, 2, "w0_lo");
    chk("w0_pix_next", 32'(state_dbg), 32'd5);
    chk("w0_no_pix_done", 32'(bus1.pix_done), 32'd0);
    chk("w0_busy", 32'(busy), 32'd1);

    // Lock: a command offered in PIX_NEXT must wait for the burst to end
    bus1.cmd_valid = 1'b1; bus1.cmd_data = 8'h3C; bus1.cmd_dcx = 1'b0;
    #1;
    chk("lock_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
    chk("lock_pix_ready", 32'(bus1.pix_ready), 32'd1);
    repeat (3) tick();
    chk("lock_no_start", 32'(lcd_start), 32'd0);
    chk("lock_byte_count", 32'(got_q.size()), 32'd5);
    bus1.pix_valid = 1'b1; bus1.pix_data = 16'h07E0; bus1.pix_last = 1'b0;
    exp_q.push_back({1'b1, 8'h07});
    exp_q.push_back({1'b1, 8'hE0});
    tick();
    bus1.pix_valid = 1'b0;
    chk("w1_hi_no_hdr", 32'({lcd_data_dcx, lcd_data_in}), 32'h107);
    serve(1'b0, 1, "w1_hi");
    serve(1'b0, 1, "w1_lo");
    chk("w1_pix_next", 32'(state_dbg), 32'd5);

    // Edge ignore in PIX_NEXT
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    chk("ign_pn_state", 32'(state_dbg), 32'd5);
    chk("ign_pn_start", 32'(lcd_start), 32'd0);
    tick();
    chk("ign_pn_start2", 32'(lcd_start), 32'd0);
    chk("ign_pn_pix_done", 32'(bus1.pix_done), 32'd0);

    bus1.pix_valid = 1'b1; bus1.pix_data = 16'h001F; bus1.pix_last = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h1F});
    tick();
    bus1.pix_valid = 1'b0; bus1.pix_last = 1'b0;
    serve(1'b0, 1, "w2_hi");
    serve(1'b0, 1, "w2_lo");
    chk("burst_pix_done", 32'(bus1.pix_done), 32'd1);
    chk("burst_words3", 32'(burst_words), 32'd3);
    chk("burst_idle", 32'(busy), 32'd0);
    chk("burst_pix_ready_cmd", 32'(bus1.pix_ready), 32'd0);
    chk("burst_byte_count", 32'(got_q.size()), 32'd9);

    // Held command now goes out
    exp_q.push_back({1'b0, 8'h3C});
    tick();
    bus1.cmd_valid = 1'b0;
    chk("post_lock_cmd", 32'({lcd_start, lcd_data_dcx, lcd_data_in}), 32'h23C);
    chk("pix_done_clear", 32'(bus1.pix_done), 32'd0);
    serve(1'b0, 1, "post_lock");
    chk("post_lock_done", 32'(bus1.cmd_done), 32'd1);

    // Edge ignore in IDLE
    tick();
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    chk("ign_idle_state", 32'(state_dbg), 32'd0);
    chk("ign_idle_start", 32'(lcd_start), 32'd0);
    chk("ign_idle_cmd_done", 32'(bus1.cmd_done), 32'd0);
    chk("ign_idle_pix_done", 32'(bus1.pix_done), 32'd0);
    tick();
    chk("ign_idle_start2", 32'(lcd_start), 32'd0);
    chk("cmd_done_total", 32'(cmd_done_cnt), 32'd3);
    chk("pix_done_total", 32'(pix_done_cnt), 32'd1);

    // Reset while in HI_WAIT
    bus1.pix_valid = 1'b1; bus1.pix_data = 16'hABCD; bus1.pix_last = 1'b1;
    exp_q.push_back({1'b0, 8'h2C});
    exp_q.push_back({1'b1, 8'hAB});
    tick();
    bus1.pix_valid = 1'b0; bus1.pix_last = 1'b0;
    serve(1'b0, 1, "rst_hdr");
    chk("rst_in_hi_wait", 32'(state_dbg), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_data", 32'(lcd_data_in), 32'h00);
    chk("mid_rst_dcx", 32'(lcd_data_dcx), 32'd0);
    chk("mid_rst_start", 32'(lcd_start), 32'd0);
    chk("mid_rst_burst_words", 32'(burst_words), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'({bus1.cmd_done, bus1.pix_done}), 32'd0);
    chk("mid_rst_ready", 32'({bus1.cmd_ready, bus1.pix_ready}), 32'd3);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    chk("late_done_state", 32'(state_dbg), 32'd0);
    chk("late_done_start", 32'(lcd_start), 32'd0);
    tick();
    chk("late_done_pix_done", 32'(pix_done_cnt), 32'd1);
    check_log("auto", 1'b0);

    // Header-less instance: one-word burst gives exactly two bytes
    chk("n0_rst_burst_words", 32'(burst_words0), 32'd0);
    chk("n0_rst_busy", 32'(busy0), 32'd0);
    bus0.pix_valid = 1'b1; bus0.pix_data = 16'h1234; bus0.pix_last = 1'b1;
    exp0_q.push_back({1'b1, 8'h12});
    exp0_q.push_back({1'b1, 8'h34});
    tick();
    bus0.pix_valid = 1'b0; bus0.pix_last = 1'b0;
    chk("n0_hi_state", 32'(state_dbg0), 32'd3);
    serve(1'b1, 2, "n0_hi");
    serve(1'b1, 2, "n0_lo");
    chk("n0_pix_done", 32'(bus0.pix_done), 32'd1);
    chk("n0_burst_words1", 32'(burst_words0), 32'd1);
    chk("n0_idle", 32'(busy0), 32'd0);
    repeat (3) tick();
    chk("n0_pix_done_total", 32'(pix_done0_cnt), 32'd1);
    check_log("noauto", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
